// File: rtl/spart_pkg.sv
// Shared SPART types and constants for the receive and transmit control blocks.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam int         DATA_BITS = 8;
  localparam logic       START_BIT = 1'b0;
  localparam logic       STOP_BIT  = 1'b1;

endpackage

// File: rtl/transmit_shift_register.sv
// Frame data shifter: loads a byte, shifts one bit per baud tick while enabled.
// Exposes the bit on the line now and the bit that follows it; no backpressure.
module transmit_shift_register
  import spart_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud,
  input  logic                 load,
  input  logic                 shift_en,
  input  logic [DATA_BITS-1:0] load_data,
  output logic                 cur_bit,
  output logic                 next_bit
);

  logic [DATA_BITS-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (baud && shift_en) begin
      if (MSB_FIRST != 0) sr <= {sr[DATA_BITS-2:0], 1'b0};
      else                sr <= {1'b0, sr[DATA_BITS-1:1]};
    end
  end

  assign cur_bit  = (MSB_FIRST != 0) ? sr[DATA_BITS-1] : sr[0];
  assign next_bit = (MSB_FIRST != 0) ? sr[DATA_BITS-2] : sr[1];

endmodule

// File: rtl/transmit_control.sv
// UART transmitter: bus writes buffered in a DEPTH-entry FIFO, framed as start/8 data/stop on txd.
// Start bit on the first baud edge after the push; writes to a full FIFO are dropped and latch overflow.
module transmit_control
  import spart_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud,
  input  logic       transmit_enable,
  input  logic [1:0] ioaddr,
  input  logic [7:0] data_in,
  output logic       txd,
  output logic       tbr,
  output logic       tx_busy,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;

  tx_state_t     state, state_nxt;
  logic [BW-1:0] bitcnt, bitcnt_nxt;
  logic          txd_nxt;
  logic          pop, load, shift_en;
  logic          cur_bit, next_bit;
  logic          push_req, push;

  assign push_req = transmit_enable && (ioaddr == ADDR_DATA);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
  assign push     = push_req && ((count != FULL) || pop);

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  assign tbr     = (count != FULL);
  assign tx_busy = (state != IDLE) || (count != '0);

  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    txd_nxt    = txd;
    pop        = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    if (baud) begin
      case (state)
        IDLE, STOP: begin
          // STOP shares IDLE's logic: a queued byte follows the stop bit with no idle gap.
          if (count != '0) begin
            pop       = 1'b1;
            load      = 1'b1;
            txd_nxt   = START_BIT;
            state_nxt = START;
          end else begin
            txd_nxt   = STOP_BIT;
            state_nxt = IDLE;
          end
        end
        START: begin
          txd_nxt    = cur_bit;
          bitcnt_nxt = '0;
          state_nxt  = DATA;
        end
        DATA: begin
          if (bitcnt != LAST_BIT) begin
            shift_en   = 1'b1;
            txd_nxt    = next_bit;
            bitcnt_nxt = bitcnt + 1'b1;
          end else begin
            txd_nxt   = STOP_BIT;
            state_nxt = STOP;
          end
        end
        default: begin
          txd_nxt   = STOP_BIT;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      txd    <= STOP_BIT;
    end else begin
      state  <= state_nxt;
      bitcnt <= bitcnt_nxt;
      txd    <= txd_nxt;
    end
  end

  transmit_shift_register #(
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .baud      (baud),
    .load      (load),
    .shift_en  (shift_en),
    .load_data (mem[head]),
    .cur_bit   (cur_bit),
    .next_bit  (next_bit)
  );

endmodule

// File: tb/tb_transmit_control.sv
// Bench for transmit_control: frame decoder on txd checks bytes against a queue filled at write time.
module tb_transmit_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud = 1'b0;
  logic       transmit_enable = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] data_in = 8'h00;
  logic       txd, tbr, tx_busy, overflow;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  int baud_period = 0;
  int bcnt = 0;

  int         mon_phase = 0;
  int         idle_cnt = 0;
  int         last_gap = 0;
  int         frames = 0;
  logic [7:0] acc = 8'h00;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    logic       accepted;
    logic       e_tbr;
    logic       e_ovf;
    logic       e_busy;
  } vec_t;

  vec_t vt[9];

  always #5 clk = ~clk;

  transmit_control #(
    .DEPTH     (4),
    .MSB_FIRST (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .baud            (baud),
    .transmit_enable (transmit_enable),
    .ioaddr          (ioaddr),
    .data_in         (data_in),
    .txd             (txd),
    .tbr             (tbr),
    .tx_busy         (tx_busy),
    .overflow        (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Baud tick generator: period 0 = off, 1 = held high, N = one pulse every N clks.
  always @(posedge clk) begin
    #1;
    if (baud_period == 0) begin
      baud = 1'b0;
      bcnt = 0;
    end else begin
      bcnt = (bcnt + 1) % baud_period;
      baud = (bcnt == 0);
    end
  end

  // Frame decoder: samples the line level set on each baud edge, MSB first.
  always @(posedge clk) begin
    if (rst) begin
      mon_phase = 0;
      idle_cnt  = 0;
    end else if (baud) begin
      #2;
      if (mon_phase == 0) begin
        if (txd == 1'b0) begin
          last_gap  = idle_cnt;
          idle_cnt  = 0;
          acc       = 8'h00;
          mon_phase = 1;
        end else begin
          idle_cnt++;
        end
      end else if (mon_phase <= 8) begin
        acc = {acc[6:0], txd};
        mon_phase++;
      end else begin
        chk("stop_bit", {31'd0, txd}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=%0h expected=none", acc);
        end else begin
          chk("frame_byte", {24'd0, acc}, {24'd0, exp_q.pop_front()});
        end
        frames++;
        mon_phase = 0;
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    transmit_enable = 1'b1;
    ioaddr          = a;
    data_in         = d;
    @(negedge clk);
    transmit_enable = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((tx_busy !== 1'b0 || mon_phase != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {30'd0, tx_busy, (mon_phase != 0)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int f0;

    vt[0] = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 2'b01, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 2'b11, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 2'b00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 2'b00, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b1, 2'b00, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 2'b00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b1, 2'b00, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[8] = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset held for 3 clks, then idle with baud running.
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_tbr", {31'd0, tbr}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    baud_period = 4;
    repeat (20) begin
      @(negedge clk);
      chk("idle_txd", {31'd0, txd}, 32'd1);
      chk("idle_tbr", {31'd0, tbr}, 32'd1);
      chk("idle_busy", {31'd0, tx_busy}, 32'd0);
      chk("idle_ovf", {31'd0, overflow}, 32'd0);
    end

    // Single byte A5: start within one baud period, 40 clks from start bit to idle.
    exp_q.push_back(8'hA5);
    wr(2'b00, 8'hA5);
    n = 0;
    while (txd !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_latency_le4", {31'd0, (n >= 1 && n <= 4)}, 32'd1);
    k = 0;
    while (tx_busy === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("frame_clks", k, 40);
    chk("single_txd_idle", {31'd0, txd}, 32'd1);
    wait_idle("single_done", 100);
    chk("single_q_empty", exp_q.size(), 0);

    // Back-to-back 00 then FF on consecutive clks: no idle period between frames.
    f0 = frames;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    @(negedge clk);
    transmit_enable = 1'b1;
    ioaddr = 2'b00;
    data_in = 8'h00;
    @(negedge clk);
    data_in = 8'hFF;
    @(negedge clk);
    transmit_enable = 1'b0;
    wait_idle("b2b_done", 300);
    chk("b2b_frames", frames - f0, 2);
    chk("b2b_gap", last_gap, 0);
    chk("b2b_q_empty", exp_q.size(), 0);

    // Fill to overflow with baud off, including ignored addresses.
    baud_period = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      transmit_enable = vt[i].we;
      ioaddr          = vt[i].addr;
      data_in         = vt[i].data;
      if (vt[i].accepted) exp_q.push_back(vt[i].data);
      @(negedge clk);
      transmit_enable = 1'b0;
      chk($sformatf("vec%0d_tbr", i), {31'd0, tbr}, {31'd0, vt[i].e_tbr});
      chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vt[i].e_ovf});
      chk($sformatf("vec%0d_busy", i), {31'd0, tx_busy}, {31'd0, vt[i].e_busy});
      chk($sformatf("vec%0d_txd", i), {31'd0, txd}, 32'd1);
    end

    // Drain with baud held high: one bit per clk, 01..04 only.
    f0 = frames;
    baud_period = 1;
    wait_idle("drain_done", 200);
    chk("drain_frames", frames - f0, 4);
    chk("drain_gap", last_gap, 0);
    chk("drain_q_empty", exp_q.size(), 0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("drain_tbr", {31'd0, tbr}, 32'd1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Wrong address with baud running: nothing queued, line stays idle.
    baud_period = 4;
    wr(2'b01, 8'h3C);
    repeat (30) begin
      @(negedge clk);
      chk("wrong_addr_txd", {31'd0, txd}, 32'd1);
    end
    chk("wrong_addr_busy", {31'd0, tx_busy}, 32'd0);
    chk("wrong_addr_frames", mon_phase, 0);

    // Mid-frame reset during a data bit of C3, then a clean frame of 5A.
    exp_q.push_back(8'hC3);
    wr(2'b00, 8'hC3);
    n = 0;
    while (mon_phase != 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_data_bit3", mon_phase, 5);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_txd", {31'd0, txd}, 32'd1);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    chk("midrst_tbr", {31'd0, tbr}, 32'd1);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_txd", {31'd0, txd}, 32'd1);
    end
    f0 = frames;
    exp_q.push_back(8'h5A);
    wr(2'b00, 8'h5A);
    wait_idle("after_rst_done", 100);
    chk("after_rst_frames", frames - f0, 1);
    chk("after_rst_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
